// File: rtl/slave_mem_if.sv
// slave_mem_if: request/response bus between the serial bus slave and slave_mem_ctrl
interface slave_mem_if #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH = 8
);
  logic [ADDRESS_WIDTH-1:0] addr;
  logic wr_en;
  logic rd_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic module_dv;
  logic busy;
  logic err;
  modport master (output addr, wr_en, rd_en, wdata, input rdata, module_dv, busy, err);
  modport slave (input addr, wr_en, rd_en, wdata, output rdata, module_dv, busy, err);
endinterface

// File: rtl/slave_mem_ctrl.sv
// slave_mem_ctrl: word memory behind the bus slave with wait states; define SLAVE_MEM_WR_READBACK_EN for write-through readback
module slave_mem_ctrl #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic rstn,
  slave_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [CW-1:0] WLAST = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  localparam logic [ADDRESS_WIDTH:0] DEPTH = (ADDRESS_WIDTH + 1)'(MEM_DEPTH);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic op_wr;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic in_range, req;
  assign req = bus.wr_en | bus.rd_en;
  assign in_range = {1'b0, addr_q} < DEPTH;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: state_n = req ? ((WAIT_CYCLES > 0) ? WAIT : ACCESS) : IDLE;
      WAIT: begin
        cnt_n = (cnt == WLAST) ? '0 : cnt + CW'(1);
        state_n = (cnt == WLAST) ? ACCESS : WAIT;
      end
      ACCESS: state_n = DONE;
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      op_wr <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && req) begin
        addr_q <= bus.addr;
        wdata_q <= bus.wdata;
        op_wr <= bus.wr_en;
      end
      if (state == ACCESS && !op_wr)
        rdata_q <= in_range ? mem[addr_q[IW-1:0]] : '0;
`ifdef SLAVE_MEM_WR_READBACK_EN
      else if (state == ACCESS)
        rdata_q <= in_range ? wdata_q : '0;
`endif
    end
  end
  // array has no reset; reset forces IDLE so an unreached ACCESS never writes
  always_ff @(posedge clk)
    if (state == ACCESS && op_wr && in_range)
      mem[addr_q[IW-1:0]] <= wdata_q;
  assign bus.rdata = rdata_q;
  assign bus.module_dv = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.err = state == DONE && !in_range;
endmodule

// File: tb/tb_slave_mem_ctrl.sv
// tb_slave_mem_ctrl: table-driven directed vectors plus reset/ignored-strobe sequences
module tb_slave_mem_ctrl;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_vec = 0;
  int n_fail = 0;
  slave_mem_if #(.ADDRESS_WIDTH(15), .DATA_WIDTH(8)) bus ();
  slave_mem_ctrl #(.ADDRESS_WIDTH(15), .DATA_WIDTH(8), .MEM_DEPTH(4096), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic wr;
    logic rd;
    logic [14:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic exp_err;
  } vec_t;
  vec_t tbl [13];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_req(input string nm, input logic w, input logic r, input logic [14:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd, input logic exp_err);
    int cyc;
    bus.wr_en = w;
    bus.rd_en = r;
    bus.addr = a;
    bus.wdata = d;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk({nm, " busy"}, 32'(bus.busy), 32'd1);
    cyc = 1;
    while (!bus.module_dv && cyc < 20) begin
      step();
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(W + 2));
    chk({nm, " err"}, 32'(bus.err), 32'(exp_err));
    chk({nm, " rdata"}, 32'(bus.rdata), 32'(exp_rd));
    step();
    chk({nm, " idle"}, {30'd0, bus.busy, bus.module_dv}, 32'd0);
  endtask
  initial begin
    int dvs;
    logic [7:0] e;
    tbl[0]  = '{1, 0, 15'h0005, 8'hA5, 8'h00, 0};
    tbl[1]  = '{0, 1, 15'h0005, 8'h00, 8'hA5, 0};
    tbl[2]  = '{1, 0, 15'h0FFF, 8'h3C, 8'hA5, 0};
    tbl[3]  = '{0, 1, 15'h0FFF, 8'h00, 8'h3C, 0};
    tbl[4]  = '{1, 0, 15'h0000, 8'h12, 8'h3C, 0};
    tbl[5]  = '{0, 1, 15'h1000, 8'h00, 8'h00, 1};
    tbl[6]  = '{1, 0, 15'h1000, 8'h77, 8'h00, 1};
    tbl[7]  = '{0, 1, 15'h0000, 8'h00, 8'h12, 0};
    tbl[8]  = '{1, 1, 15'h0010, 8'h5A, 8'h12, 0};
    tbl[9]  = '{0, 1, 15'h0010, 8'h00, 8'h5A, 0};
    tbl[10] = '{1, 0, 15'h0020, 8'h11, 8'h5A, 0};
    tbl[11] = '{0, 1, 15'h7FFF, 8'h00, 8'h00, 1};
    tbl[12] = '{0, 1, 15'h0020, 8'h00, 8'h11, 0};
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (2) step();
    chk("reset outputs", {bus.rdata, bus.module_dv, bus.busy, bus.err}, 32'd0);
    rstn = 1'b1;
    step();
    for (int i = 0; i < 13; i++) begin
      e = tbl[i].exp_rdata;
`ifdef SLAVE_MEM_WR_READBACK_EN
      if (tbl[i].wr) e = tbl[i].exp_err ? 8'h00 : tbl[i].wdata;
`endif
      do_req($sformatf("vec%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, e, tbl[i].exp_err);
    end
    // strobes during busy must be dropped without queuing
    dvs = 0;
    bus.wr_en = 1'b1;
    bus.addr = 15'h0030;
    bus.wdata = 8'h44;
    step();
    bus.wdata = 8'hFF;
    dvs += int'(bus.module_dv);
    step();
    dvs += int'(bus.module_dv);
    step();
    bus.wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dvs += int'(bus.module_dv);
      step();
    end
    chk("ignored strobes dv count", 32'(dvs), 32'd1);
    do_req("ignored strobes readback", 0, 1, 15'h0030, 8'h00, 8'h44, 0);
    // reset in the middle of a write's wait states
    bus.wr_en = 1'b1;
    bus.addr = 15'h0020;
    bus.wdata = 8'h99;
    step();
    bus.wr_en = 1'b0;
    chk("abort busy", 32'(bus.busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("abort outputs", {bus.rdata, bus.module_dv, bus.busy, bus.err}, 32'd0);
    step();
    rstn = 1'b1;
    dvs = 0;
    for (int i = 0; i < 8; i++) begin
      dvs += int'(bus.module_dv);
      step();
    end
    chk("abort no dv", 32'(dvs), 32'd0);
    do_req("abort readback", 0, 1, 15'h0020, 8'h00, 8'h11, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
